// File: rtl/apb_master.sv
// Single-outstanding APB requester: accepts one command at a time, runs
// SETUP/ACCESS on the APB bus, and returns read data plus error/timeout status.
module apb_master #(
  parameter int APB_DW  = 8,
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [APB_DW-1:0] cmd_addr,
  input  logic [APB_DW-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [APB_DW-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic [APB_DW-1:0] PADDR,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [APB_DW-1:0] PWDATA,
  input  logic              PREADY,
  input  logic [APB_DW-1:0] PRDATA,
  input  logic              PSLVERR
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  localparam logic [TO_W-1:0] CNT_ONE = TO_W'(1);
  localparam logic [TO_W-1:0] CNT_MAX = {TO_W{1'b1}};
  localparam logic [TO_W-1:0] TO_LIM  = TO_W'(TIMEOUT);
  localparam bit              TO_EN   = (TIMEOUT != 32'sd0);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [TO_W-1:0]   r_cnt;
  logic [TO_W-1:0]   w_cnt_nxt;
  logic              w_done;
  logic              w_abort;
  logic              w_accept;

  logic              r_psel;
  logic              r_penable;
  logic              r_pwrite;
  logic [APB_DW-1:0] r_paddr;
  logic [APB_DW-1:0] r_pwdata;
  logic              r_rsp_valid;
  logic [APB_DW-1:0] r_rsp_rdata;
  logic              r_rsp_err;
  logic              r_rsp_timeout;

  assign cmd_ready   = (r_state == S_IDLE);
  assign w_accept    = cmd_valid && (r_state == S_IDLE);
  assign PSEL        = r_psel;
  assign PENABLE     = r_penable;
  assign PWRITE      = r_pwrite;
  assign PADDR       = r_paddr;
  assign PWDATA      = r_pwdata;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign rsp_timeout = r_rsp_timeout;

  // State and wait-counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= {TO_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic; the counter saturates so a disabled timeout never wraps.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done      = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_state_nxt = S_SETUP;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SETUP: begin
        w_state_nxt = S_ACCESS;
        w_cnt_nxt   = {TO_W{1'b0}};
      end
      S_ACCESS: begin
        if (PREADY) begin
          w_state_nxt = S_IDLE;
          w_done      = 1'b1;
        end else begin
          if (r_cnt == CNT_MAX) begin
            w_cnt_nxt = r_cnt;
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
          if (TO_EN && (w_cnt_nxt == TO_LIM)) begin
            w_state_nxt = S_IDLE;
            w_abort     = 1'b1;
          end else begin
            w_state_nxt = S_ACCESS;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = {TO_W{1'b0}};
      end
    endcase
  end

  // APB and response output registers, driven from the upcoming state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_pwrite      <= 1'b0;
      r_paddr       <= {APB_DW{1'b0}};
      r_pwdata      <= {APB_DW{1'b0}};
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= {APB_DW{1'b0}};
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_psel      <= (w_state_nxt != S_IDLE);
      r_penable   <= (w_state_nxt == S_ACCESS);
      r_rsp_valid <= w_done || w_abort;
      if (w_accept) begin
        r_pwrite <= cmd_write;
        r_paddr  <= cmd_addr;
        r_pwdata <= cmd_wdata;
      end
      if (w_done) begin
        r_rsp_err     <= PSLVERR;
        r_rsp_timeout <= 1'b0;
        if (!r_pwrite) begin
          r_rsp_rdata <= PRDATA;
        end
      end else if (w_abort) begin
        r_rsp_err     <= 1'b1;
        r_rsp_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: directed scenarios followed by random
// transfers, with the bench acting as APB slave and predicting each response.
module tb_apb_master;

  localparam int DW  = 8;
  localparam int TOW = 8;
  localparam int TMO = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [DW-1:0] cmd_addr = 8'h00;
  logic [DW-1:0] cmd_wdata = 8'h00;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic [DW-1:0] PADDR;
  logic          PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [DW-1:0] PWDATA;
  logic          PREADY = 1'b0;
  logic [DW-1:0] PRDATA = 8'h00;
  logic          PSLVERR = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] last_rdata = 8'h00;
  logic [DW-1:0] last_addr = 8'h00;

  apb_master #(.APB_DW(DW), .TO_W(TOW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1 in an IDLE cycle; returns at posedge+1 of the response cycle.
  task automatic xfer(input logic wr, input logic [DW-1:0] addr, input logic [DW-1:0] wdata,
                      input int waits, input logic err, input logic [DW-1:0] rd);
    int   edges;
    int   acc;
    logic got;
    logic exp_to;
    int   exp_acc;
    chk("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
    PREADY = 1'b0; PSLVERR = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = 8'($urandom); cmd_wdata = 8'($urandom);
    edges = 1; acc = 0; got = 1'b0;
    chk("setup_psel_penable", {30'd0, PSEL, PENABLE}, 32'd2);
    chk("setup_paddr", {24'd0, PADDR}, {24'd0, addr});
    chk("setup_pwrite", {31'd0, PWRITE}, {31'd0, wr});
    chk("setup_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    if (wr) chk("setup_pwdata", {24'd0, PWDATA}, {24'd0, wdata});
    while (!got && edges < 64) begin
      if (rsp_valid) begin
        got = 1'b1;
      end else begin
        if (PENABLE) begin
          acc++;
          chk("access_psel", {31'd0, PSEL}, 32'd1);
          chk("access_paddr", {24'd0, PADDR}, {24'd0, addr});
          chk("access_pwrite", {31'd0, PWRITE}, {31'd0, wr});
          PREADY  = (acc > waits);
          PSLVERR = PREADY ? err : 1'($urandom);
          PRDATA  = PREADY ? rd : 8'($urandom);
        end
        cmd_valid = 1'($urandom);
        @(posedge clk); #1;
        edges++;
      end
    end
    cmd_valid = 1'b0; PREADY = 1'b0; PSLVERR = 1'b0;
    exp_to  = (TMO != 0) && (waits >= TMO);
    exp_acc = exp_to ? TMO : waits + 1;
    if (!wr && !exp_to) last_rdata = rd;
    last_addr = addr;
    chk("rsp_seen", {31'd0, got}, 32'd1);
    chk("access_cycles", acc, exp_acc);
    chk("latency", edges, exp_acc + 2);
    chk("rsp_err", {31'd0, rsp_err}, {31'd0, exp_to | err});
    chk("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, exp_to});
    chk("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, last_rdata});
    chk("rsp_psel_penable", {30'd0, PSEL, PENABLE}, 32'd0);
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    chk("idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("idle_psel", {31'd0, PSEL}, 32'd0);
    chk("idle_paddr_hold", {24'd0, PADDR}, {24'd0, last_addr});
  endtask

  initial begin
    logic wr;
    int   w;
    #2 rst = 1'b0;
    #1;
    chk("reset_outputs", {PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout, 26'd0}, 32'd0);
    chk("reset_buses", {PADDR, PWDATA, rsp_rdata, 8'd0}, 32'd0);
    chk("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("idle_no_psel", {30'd0, PSEL, rsp_valid}, 32'd0);
      chk("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    end

    xfer(1'b1, 8'h02, 8'hA5, 0, 1'b0, 8'h00);
    idle_cycle();
    xfer(1'b0, 8'h00, 8'h00, 4, 1'b0, 8'h3C);
    idle_cycle();
    xfer(1'b0, 8'h05, 8'h00, 0, 1'b1, 8'h77);
    idle_cycle();
    xfer(1'b1, 8'h01, 8'h5A, 0, 1'b0, 8'h00);
    idle_cycle();
    xfer(1'b0, 8'h03, 8'h00, 1000, 1'b0, 8'hEE);
    idle_cycle();
    xfer(1'b1, 8'h04, 8'hC3, 1, 1'b0, 8'h00);
    idle_cycle();
    xfer(1'b1, 8'h11, 8'h11, 0, 1'b0, 8'h00);
    xfer(1'b0, 8'h02, 8'h00, 0, 1'b0, 8'h9D);
    idle_cycle();

    // Reset in the middle of an ACCESS phase.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h06;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre_reset_access", {30'd0, PSEL, PENABLE}, 32'd3);
    #2 rst = 1'b0;
    #1;
    chk("midreset_psel_penable", {30'd0, PSEL, PENABLE}, 32'd0);
    chk("midreset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("midreset_paddr", {24'd0, PADDR}, 32'd0);
    last_rdata = 8'h00; last_addr = 8'h00;
    @(negedge clk);
    rst = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      chk("post_reset_quiet", {30'd0, PSEL, rsp_valid}, 32'd0);
    end

    for (int i = 0; i < 40; i++) begin
      wr = 1'($urandom);
      w  = $urandom_range(0, 7);
      xfer(wr, 8'($urandom), 8'($urandom), w, 1'($urandom), 8'($urandom));
      if ($urandom_range(0, 1) == 0) idle_cycle();
    end
    idle_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_master.md
# apb_master

Single-outstanding APB requester that drives the UART block's APB slave port from a simple command/response interface. A host-side engine (CPU shim, test sequencer or DMA) hands it one read or write at a time. The block runs the APB IDLE → SETUP → ACCESS sequence, waits out slave wait states, and returns read data plus error status. It is the initiator end of the UART's APB register interface and bounds each transfer with a timeout.

## Interface
Parameters:
- APB_DW, 8, width of PADDR, PWDATA and PRDATA (matches the UART slave).
- TO_W, 8, width of the wait-state timeout counter.
- TIMEOUT, 255, maximum number of ACCESS cycles without PREADY before abort. 0 disables the timeout.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  block can accept a command this cycle.
- cmd_write  input  1  1 = write, 0 = read.
- cmd_addr  input  APB_DW  transfer address.
- cmd_wdata  input  APB_DW  write data; ignored for reads.
- rsp_valid  output  1  one-cycle pulse signalling transfer completion.
- rsp_rdata  output  APB_DW  read data captured from PRDATA.
- rsp_err  output  1  PSLVERR seen, or timeout.
- rsp_timeout  output  1  transfer was aborted by the timeout.
- PADDR  output  APB_DW  APB address.
- PSEL  output  1  APB select.
- PENABLE  output  1  APB enable.
- PWRITE  output  1  APB direction.
- PWDATA  output  APB_DW  APB write data.
- PREADY  input  1  slave ready.
- PRDATA  input  APB_DW  slave read data.
- PSLVERR  input  1  slave error.

## Operation
- All outputs are registered except cmd_ready, which equals (state == IDLE).
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - PSEL = 0, PENABLE = 0.
  - On cmd_valid && cmd_ready, latch cmd_write, cmd_addr and cmd_wdata into PWRITE, PADDR and PWDATA, then go to SETUP.
- SETUP:
  - PSEL = 1, PENABLE = 0 for exactly one cycle, then go to ACCESS.
  - Clear the wait counter.
- ACCESS:
  - PSEL = 1, PENABLE = 1.
  - PADDR, PWRITE and PWDATA hold stable throughout.
  - Each cycle, sample PREADY.
- PREADY = 1 sampled in ACCESS:
  - Next cycle: state is IDLE, PSEL = PENABLE = 0, rsp_valid = 1, rsp_err = PSLVERR, rsp_timeout = 0.
  - Read: rsp_rdata = PRDATA.
  - Write: rsp_rdata keeps its previous value.
- PREADY = 0 sampled in ACCESS: increment the wait counter.
  - If TIMEOUT != 0 and the counter reaches TIMEOUT, abort.
  - Abort next cycle: state is IDLE, PSEL = PENABLE = 0, rsp_valid = 1, rsp_err = 1, rsp_timeout = 1, rsp_rdata unchanged.
- The counter saturates at 2^TO_W−1. TIMEOUT must be ≤ 2^TO_W−1.
- PSLVERR is only meaningful when qualified by PREADY; it is ignored otherwise.
- PADDR, PWRITE and PWDATA keep their last values in IDLE; they do not return to 0.
- rsp_rdata, rsp_err and rsp_timeout hold their values until the next completion.
- No response back-pressure: the consumer must accept rsp_valid in the cycle it is asserted.

## Timing
- Reset (rst low, asynchronous): state = IDLE, and every registered output = 0 (PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err, rsp_timeout). cmd_ready = 1 once rst is high.
- Reset asserted mid-transfer drops PSEL and PENABLE immediately, with no response issued.
- Zero-wait transfer, with the command accepted at edge 0:
  - cycle 1: SETUP.
  - cycle 2: ACCESS with PREADY = 1.
  - cycle 3: rsp_valid.
- Latency is 3 cycles plus N wait states.
- Back-to-back: cmd_ready = 1 in the rsp_valid cycle, so a new command can be accepted there. The next SETUP follows immediately, giving a throughput of one transfer per 3 cycles.
- Timeout: with the slave never ready, there are exactly TIMEOUT ACCESS cycles, then the abort response on the following cycle.
- cmd_valid while busy is ignored; cmd_ready = 0, and the requester must hold its command.

## Test plan
- Reset then idle → all outputs 0, cmd_ready = 1, PSEL never asserted.
- Write addr 0x02, data 0xA5, PREADY tied 1 → PSEL/PENABLE/PWRITE/PADDR/PWDATA sequence per APB, rsp_valid 3 cycles after accept, rsp_err = 0.
- Read addr 0x00, slave holds PREADY low for 4 ACCESS cycles then returns PRDATA = 0x3C → PADDR stable for 5 ACCESS cycles, rsp_rdata = 0x3C, total latency 7.
- Read with PREADY = 1 and PSLVERR = 1 (UART RX FIFO empty) → rsp_err = 1, rsp_timeout = 0. A subsequent write completes with rsp_err = 0.
- TIMEOUT = 5, slave never ready → 5 ACCESS cycles, PSEL drops, rsp_err = rsp_timeout = 1. The next command is accepted normally.
- Back-to-back write 0x11 then read, issued in the rsp_valid cycle → second SETUP in the cycle after rsp_valid. Also assert rst mid-ACCESS → PSEL = 0 asynchronously and no rsp_valid.
